btn_event_source: RTL and testbench

- Producer end of the front-panel button interface: syncs and debounces active-low board buttons.
- Turns stable press/release transitions into discrete event words.
- Delivers events through a small FIFO with a valid/ready handshake to consumers such as rate-step or mode-select logic.
- Sits between board button pins and any downstream control block, replacing ad-hoc per-block debounce.

---
 rtl/btn_event_source.sv | 116 +++++++++++
 tb/tb_btn_event_source.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_source.sv
// Front-panel button producer: synchronises and debounces active-low buttons,
// turns stable transitions into press/release event words and queues them in a small FIFO.
module btn_event_source #(
    parameter int NUM_BTN      = 2,
    parameter int TICK_DIV     = 16,
    parameter int DEBOUNCE_CNT = 20,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clk_50m,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_n,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [3:0]         evt_data,
    output logic [NUM_BTN-1:0] btn_state,
    output logic               overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]         PTR_ONE  = 1;
    localparam logic [TICK_DIV-1:0] TICK_ONE = 1;
    localparam logic [5:0]          DEB_LAST = 6'(DEBOUNCE_CNT);

    logic [NUM_BTN-1:0]  sync1, sync2;
    logic [TICK_DIV-1:0] tick_cnt;
    logic                tick;
    logic [5:0]          deb_cnt [NUM_BTN];
    logic [NUM_BTN-1:0]  pending, pend_type;
    logic [3:0]          mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic                full, pop, push, push_type;
    logic [2:0]          push_idx;

    // Released buttons read as 1, so the sync chain resets to that level.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick_cnt <= tick_cnt + TICK_ONE;
            tick     <= &tick_cnt;
        end
    end

    // Lowest pending index wins; a pop in the same cycle frees a slot for a full FIFO.
    always_comb begin
        push_idx  = 3'd0;
        push_type = 1'b0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pending[i]) begin
                push_idx  = 3'(i);
                push_type = pend_type[i];
            end
        end
        push = (|pending) && (!full || pop);
    end

    // A new decision overrides the arbiter's clear; losing an unpushed event is flagged.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BTN; i++) deb_cnt[i] <= '0;
            btn_state <= '0;
            pending   <= '0;
            pend_type <= '0;
            overflow  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (push && push_idx == 3'(i)) pending[i] <= 1'b0;
                if (tick) begin
                    if (~sync2[i] == btn_state[i]) begin
                        deb_cnt[i] <= '0;
                    end else if (deb_cnt[i] + 6'd1 == DEB_LAST) begin
                        deb_cnt[i]   <= '0;
                        btn_state[i] <= ~btn_state[i];
                        pending[i]   <= 1'b1;
                        pend_type[i] <= ~btn_state[i];
                        if (pending[i] && !(push && push_idx == 3'(i))) overflow <= 1'b1;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 6'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= {push_type, push_idx};
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Wrap bits differ with equal addresses only when every slot is occupied.
    assign full      = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign evt_valid = (wr_ptr != rd_ptr);
    assign pop       = evt_valid && evt_ready;
    assign evt_data  = evt_valid ? mem[rd_ptr[AW-1:0]] : 4'b0000;

endmodule

// File: tb/tb_btn_event_source.sv
// Bench for btn_event_source: table-driven rows, hand sequences for FIFO overflow and
// reset corner cases, and random stimulus, all checked against a queue-based event model.
module tb_btn_event_source;

    localparam int NUM_BTN      = 2;
    localparam int TICK_DIV     = 2;
    localparam int DEBOUNCE_CNT = 3;
    localparam int FIFO_DEPTH   = 4;
    localparam int PERIOD       = 1 << TICK_DIV;

    logic               clk_50m = 1'b0;
    logic               rst_n;
    logic [NUM_BTN-1:0] btn_n;
    logic               evt_ready;
    logic               evt_valid;
    logic [3:0]         evt_data;
    logic [NUM_BTN-1:0] btn_state;
    logic               overflow;

    int checks = 0;
    int errors = 0;
    int hs_count;
    logic [3:0] seen_q [$];

    // Reference model: raw history queue, per-button run lengths, event queue.
    int                 edge_num;
    logic [NUM_BTN-1:0] raw_hist [$];
    int                 m_run    [NUM_BTN];
    bit                 m_stable [NUM_BTN];
    bit                 m_pend   [NUM_BTN];
    bit                 m_type   [NUM_BTN];
    bit                 m_ovf;
    logic [3:0]         fifo_q   [$];

    typedef struct {
        logic [NUM_BTN-1:0] btn;
        logic               ready;
        int                 cycles;
        logic [NUM_BTN-1:0] exp_state;
        int                 exp_events;
        logic               exp_ovf;
    } vec_t;
    vec_t vecs [7];

    btn_event_source #(
        .NUM_BTN(NUM_BTN), .TICK_DIV(TICK_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .btn_n(btn_n),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
        .btn_state(btn_state), .overflow(overflow)
    );

    always #5 clk_50m = ~clk_50m;

    task automatic check_eq(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        edge_num = 0;
        raw_hist.delete();
        raw_hist.push_back('1);
        raw_hist.push_back('1);
        fifo_q.delete();
        m_ovf = 0;
        for (int i = 0; i < NUM_BTN; i++) begin
            m_run[i] = 0; m_stable[i] = 0; m_pend[i] = 0; m_type[i] = 0;
        end
    endtask

    // Two-edge synchroniser delay, a tick every PERIOD clocks, events queued a clock later.
    task automatic model_step();
        logic [NUM_BTN-1:0] seen;
        bit do_tick;
        int push_idx;
        seen = raw_hist.pop_front();
        raw_hist.push_back(btn_n);
        do_tick = (edge_num > 0) && (edge_num % PERIOD == 0);
        edge_num++;
        if (fifo_q.size() != 0 && evt_ready) void'(fifo_q.pop_front());
        push_idx = -1;
        for (int i = NUM_BTN - 1; i >= 0; i--) if (m_pend[i]) push_idx = i;
        if (push_idx >= 0 && fifo_q.size() < FIFO_DEPTH) begin
            fifo_q.push_back({m_type[push_idx], 3'(push_idx)});
            m_pend[push_idx] = 0;
        end
        if (do_tick) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (bit'(!seen[i]) == m_stable[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == DEBOUNCE_CNT) begin
                        m_run[i]    = 0;
                        m_stable[i] = !m_stable[i];
                        if (m_pend[i]) m_ovf = 1;
                        m_pend[i] = 1;
                        m_type[i] = m_stable[i];
                    end
                end
            end
        end
    endtask

    task automatic checkOutput();
        int m_state;
        m_state = 0;
        for (int i = 0; i < NUM_BTN; i++) if (m_stable[i]) m_state |= (1 << i);
        check_eq("evt_valid", int'(evt_valid), int'(fifo_q.size() != 0));
        check_eq("evt_data", int'(evt_data), (fifo_q.size() != 0) ? int'(fifo_q[0]) : 0);
        check_eq("btn_state", int'(btn_state), m_state);
        check_eq("overflow", int'(overflow), int'(m_ovf));
    endtask

    task automatic step_cycle();
        if (evt_valid && evt_ready) begin
            hs_count++;
            seen_q.push_back(evt_data);
        end
        @(posedge clk_50m);
        model_step();
        @(negedge clk_50m);
        checkOutput();
    endtask

    task automatic applyStimulus(input logic [NUM_BTN-1:0] btn, input logic ready, input int cycles);
        btn_n     = btn;
        evt_ready = ready;
        repeat (cycles) step_cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput();
        repeat (2) @(negedge clk_50m);
        rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        rst_n     = 1'b1;
        btn_n     = '1;
        evt_ready = 1'b1;
        @(negedge clk_50m);
        do_reset();

        vecs[0] = '{2'b11, 1'b1, 24, 2'b00, 0, 1'b0};
        vecs[1] = '{2'b10, 1'b1, 24, 2'b01, 1, 1'b0};
        vecs[2] = '{2'b11, 1'b1, 24, 2'b00, 1, 1'b0};
        vecs[3] = '{2'b01, 1'b1, 6,  2'b00, 0, 1'b0};
        vecs[4] = '{2'b11, 1'b1, 24, 2'b00, 0, 1'b0};
        vecs[5] = '{2'b00, 1'b1, 24, 2'b11, 2, 1'b0};
        vecs[6] = '{2'b11, 1'b1, 24, 2'b00, 2, 1'b0};
        for (int r = 0; r < 7; r++) begin
            hs_count = 0;
            applyStimulus(vecs[r].btn, vecs[r].ready, vecs[r].cycles);
            check_eq($sformatf("row%0d_state", r), int'(btn_state), int'(vecs[r].exp_state));
            check_eq($sformatf("row%0d_events", r), hs_count, vecs[r].exp_events);
            check_eq($sformatf("row%0d_ovf", r), int'(overflow), int'(vecs[r].exp_ovf));
        end

        // Six events with the consumer stalled: four queue, the sixth overwrites the fifth.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b10, 1'b0, 24);
            applyStimulus(2'b11, 1'b0, 24);
        end
        check_eq("ovf_sticky", int'(overflow), 1);
        check_eq("full_head", int'(evt_data), 4'b1000);
        seen_q.delete();
        applyStimulus(2'b11, 1'b1, 1);
        applyStimulus(2'b11, 1'b0, 1);
        check_eq("pulse_valid", int'(evt_valid), 1);
        check_eq("pulse_head", int'(evt_data), 4'b0000);
        applyStimulus(2'b11, 1'b1, 8);
        check_eq("drain_count", seen_q.size(), 5);
        if (seen_q.size() == 5) begin
            check_eq("drain0", int'(seen_q[0]), 4'b1000);
            check_eq("drain1", int'(seen_q[1]), 4'b0000);
            check_eq("drain2", int'(seen_q[2]), 4'b1000);
            check_eq("drain3", int'(seen_q[3]), 4'b0000);
            check_eq("drain4", int'(seen_q[4]), 4'b0000);
        end
        check_eq("drain_empty", int'(evt_valid), 0);

        // Reset while button 0 is mid-debounce and still held.
        applyStimulus(2'b10, 1'b1, 10);
        do_reset();
        check_eq("rst_ovf", int'(overflow), 0);
        check_eq("rst_state", int'(btn_state), 0);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            step_cycle();
            if (evt_valid) begin
                lat = n;
                break;
            end
        end
        check_eq("rst_latency", lat, 14);
        check_eq("rst_evt", int'(evt_data), 4'b1000);
        check_eq("rst_pressed", int'(btn_state), 1);

        for (int b = 0; b < 150; b++) begin
            applyStimulus(NUM_BTN'($urandom_range(0, 3)), logic'($urandom_range(0, 3) != 0),
                          $urandom_range(1, 30));
        end
        applyStimulus('1, 1'b1, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
